calc_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one registered Calculadora-style datapath between two requesters.
- Each requester presents an operation (operand A, operand B, 5-bit ALU control) through a valid/ready handshake.
- The block drives the calculator's enable for the two register stages, captures the result and carry, and returns them through a per-requester response handshake.
- It sits between two client FSMs and the calculator instance; the calculator's own reset is not driven here.

---
 rtl/calc_arbiter_if.sv | 58 +++++
 rtl/calc_arbiter.sv | 144 ++++++++++++++
 tb/tb_calc_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_arbiter_if.sv
// Bundle between calc_arbiter, its two requesters and the shared calculator.
// The slave modport is the arbiter's view; master is everything around it.
interface calc_arbiter_if #(
  parameter int WORD_LENGTH = 6,
  parameter int CNT_WIDTH   = 8
);
  logic                   req_valid_0;
  logic                   req_valid_1;
  logic                   req_ready_0;
  logic                   req_ready_1;
  logic [WORD_LENGTH-1:0] req_dataA_0;
  logic [WORD_LENGTH-1:0] req_dataA_1;
  logic [WORD_LENGTH-1:0] req_dataB_0;
  logic [WORD_LENGTH-1:0] req_dataB_1;
  logic [4:0]             req_control_0;
  logic [4:0]             req_control_1;

  logic                   resp_valid_0;
  logic                   resp_valid_1;
  logic                   resp_ready_0;
  logic                   resp_ready_1;
  logic [WORD_LENGTH-1:0] resp_dataC;
  logic [WORD_LENGTH-1:0] resp_carry;

  logic                   calc_enable;
  logic [WORD_LENGTH-1:0] calc_dataA;
  logic [WORD_LENGTH-1:0] calc_dataB;
  logic [4:0]             calc_control;
  logic [WORD_LENGTH-1:0] calc_dataC;
  logic [WORD_LENGTH-1:0] calc_carry;

  logic                   busy;
  logic [CNT_WIDTH-1:0]   op_count;

  modport slave (
    input  req_valid_0, req_valid_1,
    input  req_dataA_0, req_dataA_1, req_dataB_0, req_dataB_1,
    input  req_control_0, req_control_1,
    output req_ready_0, req_ready_1,
    output resp_valid_0, resp_valid_1, resp_dataC, resp_carry,
    input  resp_ready_0, resp_ready_1,
    output calc_enable, calc_dataA, calc_dataB, calc_control,
    input  calc_dataC, calc_carry,
    output busy, op_count
  );

  modport master (
    output req_valid_0, req_valid_1,
    output req_dataA_0, req_dataA_1, req_dataB_0, req_dataB_1,
    output req_control_0, req_control_1,
    input  req_ready_0, req_ready_1,
    input  resp_valid_0, resp_valid_1, resp_dataC, resp_carry,
    output resp_ready_0, resp_ready_1,
    input  calc_enable, calc_dataA, calc_dataB, calc_control,
    output calc_dataC, calc_carry,
    input  busy, op_count
  );
endinterface

// File: rtl/calc_arbiter.sv
// Round-robin arbiter that time-shares one two-stage registered calculator
// between two requesters and returns each result on a per-requester handshake.
module calc_arbiter #(
  parameter int WORD_LENGTH = 6,
  parameter int CNT_WIDTH   = 8
) (
  input  logic          clk,
  input  logic          reset_sync,
  calc_arbiter_if.slave bus
);
  localparam int CTRL_WIDTH = 5;

  typedef logic [WORD_LENGTH-1:0] word_t;
  typedef logic [CTRL_WIDTH-1:0]  ctrl_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    ISSUE2 = 3'd2,
    CAPT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 owner_q, owner_d;
  word_t                calc_a_q, calc_a_d;
  word_t                calc_b_q, calc_b_d;
  ctrl_t                calc_ctrl_q, calc_ctrl_d;
  word_t                resp_c_q, resp_c_d;
  word_t                resp_carry_q, resp_carry_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;

  // Per-requester views so the grant and response logic can be indexed.
  logic [1:0] req_valid_w;
  logic [1:0] req_ready_w;
  logic [1:0] resp_ready_w;
  logic [1:0] resp_valid_w;
  word_t      req_a_w    [2];
  word_t      req_b_w    [2];
  ctrl_t      req_ctrl_w [2];
  logic       grant_w;
  logic       idle_w;

  assign req_valid_w   = {bus.req_valid_1, bus.req_valid_0};
  assign resp_ready_w  = {bus.resp_ready_1, bus.resp_ready_0};
  assign req_a_w[0]    = bus.req_dataA_0;
  assign req_a_w[1]    = bus.req_dataA_1;
  assign req_b_w[0]    = bus.req_dataB_0;
  assign req_b_w[1]    = bus.req_dataB_1;
  assign req_ctrl_w[0] = bus.req_control_0;
  assign req_ctrl_w[1] = bus.req_control_1;

  assign idle_w = (state_q == IDLE);

  // A lone requester always wins; on contention prio picks the winner.
  assign grant_w = (&req_valid_w) ? prio_q : req_valid_w[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready_w[gi]  = idle_w & req_valid_w[gi] & (grant_w == 1'(gi));
      assign resp_valid_w[gi] = (state_q == RESP) & (owner_q == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    calc_a_d     = calc_a_q;
    calc_b_d     = calc_b_q;
    calc_ctrl_d  = calc_ctrl_q;
    resp_c_d     = resp_c_q;
    resp_carry_d = resp_carry_q;
    op_count_d   = op_count_q;

    case (state_q)
      IDLE: begin
        if (|req_ready_w) begin
          owner_d     = grant_w;
          calc_a_d    = req_a_w[grant_w];
          calc_b_d    = req_b_w[grant_w];
          calc_ctrl_d = req_ctrl_w[grant_w];
          state_d     = ISSUE1;
        end
      end
      ISSUE1: state_d = ISSUE2;
      ISSUE2: state_d = CAPT;
      CAPT: begin
        // Calculator output stage was loaded at the end of ISSUE2.
        resp_c_d     = bus.calc_dataC;
        resp_carry_d = bus.calc_carry;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready_w[owner_q]) begin
          state_d    = IDLE;
          prio_d     = ~owner_q;
          op_count_d = op_count_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      calc_a_q     <= '0;
      calc_b_q     <= '0;
      calc_ctrl_q  <= '0;
      resp_c_q     <= '0;
      resp_carry_q <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      calc_a_q     <= calc_a_d;
      calc_b_q     <= calc_b_d;
      calc_ctrl_q  <= calc_ctrl_d;
      resp_c_q     <= resp_c_d;
      resp_carry_q <= resp_carry_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.req_ready_0  = req_ready_w[0];
  assign bus.req_ready_1  = req_ready_w[1];
  assign bus.resp_valid_0 = resp_valid_w[0];
  assign bus.resp_valid_1 = resp_valid_w[1];
  assign bus.resp_dataC   = resp_c_q;
  assign bus.resp_carry   = resp_carry_q;
  assign bus.calc_enable  = (state_q == ISSUE1) | (state_q == ISSUE2);
  assign bus.calc_dataA   = calc_a_q;
  assign bus.calc_dataB   = calc_b_q;
  assign bus.calc_control = calc_ctrl_q;
  assign bus.busy         = ~idle_w;
  assign bus.op_count     = op_count_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: a two-stage calculator model, a per-cycle
// behavioural reference, directed scenarios and a randomized soak.
module tb_calc_arbiter;
  localparam int WL = 6;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset_sync;
  always #5 clk = ~clk;

  calc_arbiter_if #(.WORD_LENGTH(WL), .CNT_WIDTH(CW)) ifc ();

  calc_arbiter #(.WORD_LENGTH(WL), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset_sync (reset_sync),
    .bus        (ifc)
  );

  // Returns {carry, result}.
  function automatic logic [11:0] alu(input logic [5:0] a, input logic [5:0] b,
                                      input logic [4:0] c);
    logic [6:0]  s;
    logic [11:0] p;
    case (c)
      5'd0: begin s = {1'b0, a} + {1'b0, b}; return {5'b0, s}; end
      5'd1: begin s = {1'b0, a} - {1'b0, b}; return {5'b0, s}; end
      5'd2: return {6'b0, a & b};
      5'd3: return {6'b0, a | b};
      5'd4: return {6'b0, a ^ b};
      5'd5: begin p = 12'(a) * 12'(b); return p; end
      default: return {6'b0, a};
    endcase
  endfunction

  // Calculator: input stage then output stage, both gated by enable.
  logic [5:0] cin_a, cin_b, cout_c, cout_carry;
  logic [4:0] cin_ctrl;
  always @(posedge clk) begin
    if (ifc.calc_enable === 1'b1) begin
      cin_a                <= ifc.calc_dataA;
      cin_b                <= ifc.calc_dataB;
      cin_ctrl             <= ifc.calc_control;
      {cout_carry, cout_c} <= alu(cin_a, cin_b, cin_ctrl);
    end
  end
  assign ifc.calc_dataC = cout_c;
  assign ifc.calc_carry = cout_carry;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  // Reference model: phase counts cycles since accept (0 = waiting for a request).
  int         m_phase;
  bit         m_valid = 0;
  bit         m_owner, m_prio, m_saw_wrap;
  int         m_count, m_total;
  logic [5:0] m_a, m_b, m_c, m_carry;
  logic [4:0] m_ctrl;
  bit         mv0, mv1, mwin, mr0, mr1;

  always @(negedge clk) begin
    mv0  = (ifc.req_valid_0 === 1'b1);
    mv1  = (ifc.req_valid_1 === 1'b1);
    mwin = (mv0 && mv1) ? m_prio : mv1;
    mr0  = (m_phase == 0) && mv0 && !mwin;
    mr1  = (m_phase == 0) && mv1 && mwin;
    if (m_valid) begin
      check("req_ready_0", 32'(ifc.req_ready_0), 32'(mr0));
      check("req_ready_1", 32'(ifc.req_ready_1), 32'(mr1));
      check("resp_valid_0", 32'(ifc.resp_valid_0), 32'(m_phase == 4 && !m_owner));
      check("resp_valid_1", 32'(ifc.resp_valid_1), 32'(m_phase == 4 && m_owner));
      check("busy", 32'(ifc.busy), 32'(m_phase != 0));
      check("calc_enable", 32'(ifc.calc_enable), 32'(m_phase == 1 || m_phase == 2));
      check("calc_operands", {11'b0, ifc.calc_control, ifc.calc_dataB, ifc.calc_dataA},
            {11'b0, m_ctrl, m_b, m_a});
      check("resp_data", {20'b0, ifc.resp_carry, ifc.resp_dataC}, {20'b0, m_carry, m_c});
      check("op_count", 32'(ifc.op_count), 32'(m_count));
    end
    if (reset_sync === 1'b1) begin
      m_phase = 0; m_prio = 0; m_owner = 0; m_count = 0; m_total = 0;
      m_a = 0; m_b = 0; m_ctrl = 0; m_c = 0; m_carry = 0;
      m_valid = 1;
    end else if (m_valid) begin
      case (m_phase)
        0: if (mr0 || mr1) begin
          m_owner = mwin;
          m_a     = mwin ? ifc.req_dataA_1 : ifc.req_dataA_0;
          m_b     = mwin ? ifc.req_dataB_1 : ifc.req_dataB_0;
          m_ctrl  = mwin ? ifc.req_control_1 : ifc.req_control_0;
          m_phase = 1;
        end
        1, 2: m_phase++;
        3: begin
          {m_carry, m_c} = alu(m_a, m_b, m_ctrl);
          m_phase = 4;
        end
        default: if ((m_owner ? ifc.resp_ready_1 : ifc.resp_ready_0) === 1'b1) begin
          m_phase = 0;
          m_prio  = !m_owner;
          m_count = (m_count + 1) % (1 << CW);
          if (m_count == 0) m_saw_wrap = 1;
          m_total++;
          $display("[TB] resp req%0d A=%h B=%h ctrl=%0d C=%h carry=%h op_count=%0d",
                   m_owner, m_a, m_b, m_ctrl, m_c, m_carry, m_count);
        end
      endcase
    end
  end

  int en_cnt = 0;
  always @(negedge clk) if (ifc.calc_enable === 1'b1) en_cnt++;

  task automatic drive_req(input int r, input bit v, input logic [5:0] a,
                           input logic [5:0] b, input logic [4:0] c);
    if (r == 0) begin
      ifc.req_valid_0 = v; ifc.req_dataA_0 = a; ifc.req_dataB_0 = b; ifc.req_control_0 = c;
    end else begin
      ifc.req_valid_1 = v; ifc.req_dataA_1 = a; ifc.req_dataB_1 = b; ifc.req_control_1 = c;
    end
  endtask

  // Returns just after the accept edge (state ISSUE1).
  task automatic issue(input int r, input logic [5:0] a, input logic [5:0] b,
                       input logic [4:0] c);
    bit ok = 0;
    @(posedge clk); #1;
    drive_req(r, 1'b1, a, b, c);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if ((r == 0 ? ifc.req_ready_0 : ifc.req_ready_1) === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    drive_req(r, 1'b0, a, b, c);
    if (!ok) timeout("accept_wait");
  endtask

  // Returns at the negedge of the first RESP cycle.
  task automatic wait_resp(input int r, output int lat, output logic [5:0] c,
                           output logic [5:0] cy);
    bit ok = 0;
    lat = -1; c = 'x; cy = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((r == 0 ? ifc.resp_valid_0 : ifc.resp_valid_1) === 1'b1) begin
        ok = 1; lat = k; c = ifc.resp_dataC; cy = ifc.resp_carry; break;
      end
    end
    if (!ok) timeout("resp_wait");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog");
  end

  int         lat, en_snap, done_snap;
  logic [5:0] rc, rcy;
  int         glog[$];
  int         g;
  bit         ok;

  initial begin
    reset_sync = 1'b1;
    drive_req(0, 1'b0, 6'd0, 6'd0, 5'd0);
    drive_req(1, 1'b0, 6'd0, 6'd0, 5'd0);
    ifc.resp_ready_0 = 1'b1;
    ifc.resp_ready_1 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset_sync = 1'b0;

    @(negedge clk);
    check("reset_busy", 32'(ifc.busy), 32'd0);
    check("reset_op_count", 32'(ifc.op_count), 32'd0);
    check("reset_resp_dataC", 32'(ifc.resp_dataC), 32'd0);
    en_snap = en_cnt;

    // Single ADD from requester 0: 5 + 3 = 8.
    issue(0, 6'd5, 6'd3, 5'd0);
    wait_resp(0, lat, rc, rcy);
    check("single_latency", 32'(lat), 32'd3);
    check("single_dataC", 32'(rc), 32'd8);
    check("single_carry", 32'(rcy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_op_count", 32'(ifc.op_count), 32'd1);
    check("single_enable_cycles", 32'(en_cnt - en_snap), 32'd2);

    // Carry out: 3F + 01 = 0x40 -> result 0, carry 1.
    issue(1, 6'h3F, 6'h01, 5'd0);
    wait_resp(1, lat, rc, rcy);
    check("carry_dataC", 32'(rc), 32'h00);
    check("carry_carry", 32'(rcy), 32'h01);
    @(posedge clk); #1;
    @(negedge clk);
    check("carry_hold_dataC", 32'(ifc.resp_dataC), 32'h00);
    check("carry_hold_carry", 32'(ifc.resp_carry), 32'h01);

    // Back-pressure on requester 1: 10 * 20 = 200 -> result 0x08, carry 0x03.
    issue(1, 6'd10, 6'd20, 5'd5);
    ifc.resp_ready_1 = 1'b0;
    wait_resp(1, lat, rc, rcy);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      drive_req(0, 1'b1, 6'd1, 6'd2, 5'd3);
      @(negedge clk);
      check("bp_resp_valid_1", 32'(ifc.resp_valid_1), 32'd1);
      check("bp_data", {20'b0, ifc.resp_carry, ifc.resp_dataC}, 32'h0C8);
      check("bp_req_ready_0", 32'(ifc.req_ready_0), 32'd0);
    end
    @(posedge clk); #1;
    ifc.resp_ready_1 = 1'b1;
    drive_req(0, 1'b0, 6'd1, 6'd2, 5'd3);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_done_busy", 32'(ifc.busy), 32'd0);
    check("bp_done_op_count", 32'(ifc.op_count), 32'd3);

    // Reset while the operation sits in ISSUE2.
    issue(0, 6'd7, 6'd9, 5'd1);
    @(posedge clk); #1;
    reset_sync = 1'b1;
    @(posedge clk); #1;
    reset_sync = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(ifc.busy), 32'd0);
    check("midreset_enable", 32'(ifc.calc_enable), 32'd0);
    check("midreset_resp_valid", {30'b0, ifc.resp_valid_1, ifc.resp_valid_0}, 32'd0);
    check("midreset_op_count", 32'(ifc.op_count), 32'd0);

    // Contention right after reset: grants must alternate 0,1,0,1.
    @(posedge clk); #1;
    drive_req(0, 1'b1, 6'($urandom), 6'($urandom), 5'($urandom_range(0, 7)));
    drive_req(1, 1'b1, 6'($urandom), 6'($urandom), 5'($urandom_range(0, 7)));
    for (int k = 0; k < 80 && glog.size() < 4; k++) begin
      @(negedge clk);
      g = -1;
      if (ifc.req_ready_0 === 1'b1) g = 0;
      if (ifc.req_ready_1 === 1'b1) g = 1;
      @(posedge clk); #1;
      if (g >= 0) begin
        glog.push_back(g);
        drive_req(g, 1'b1, 6'($urandom), 6'($urandom), 5'($urandom_range(0, 7)));
      end
    end
    drive_req(0, 1'b0, 6'd0, 6'd0, 5'd0);
    drive_req(1, 1'b0, 6'd0, 6'd0, 5'd0);
    if (glog.size() < 4) timeout("contention_grants");
    else for (int k = 0; k < 4; k++) check("contention_order", 32'(glog[k]), 32'(k % 2));

    // Randomized soak long enough to wrap the 8-bit counter.
    done_snap = m_total;
    for (int cyc = 0; cyc < 9000 && m_total < done_snap + 300; cyc++) begin
      @(posedge clk); #1;
      drive_req(0, $urandom_range(0, 3) != 0, 6'($urandom), 6'($urandom),
                5'($urandom_range(0, 7)));
      drive_req(1, $urandom_range(0, 3) != 0, 6'($urandom), 6'($urandom),
                5'($urandom_range(0, 7)));
      ifc.resp_ready_0 = 1'($urandom_range(0, 1));
      ifc.resp_ready_1 = 1'($urandom_range(0, 1));
    end
    if (m_total < done_snap + 300) timeout("soak_completions");
    check("soak_counter_wrapped", 32'(m_saw_wrap), 32'd1);

    @(posedge clk); #1;
    drive_req(0, 1'b0, 6'd0, 6'd0, 5'd0);
    drive_req(1, 1'b0, 6'd0, 6'd0, 5'd0);
    ifc.resp_ready_0 = 1'b1;
    ifc.resp_ready_1 = 1'b1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifc.busy === 1'b0) begin ok = 1; break; end
    end
    if (!ok) timeout("drain_idle");
    check("final_op_count", 32'(ifc.op_count), 32'(m_total % (1 << CW)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
